// File: rtl/ysyx_22040127_mem_stage_if.sv
// MEM stage handshake bundle: EX->MEM input, data-memory request/response, MEM->WB output.
interface ysyx_22040127_mem_stage_if;
  logic         ex_to_mem_valid;
  logic         mem_allowin;
  logic [170:0] ex_to_mem_bus;
  logic         mem_flush;

  logic         dreq_valid;
  logic         dreq_ready;
  logic [31:0]  dreq_addr;
  logic         dreq_wen;
  logic [63:0]  dreq_wdata;
  logic [7:0]   dreq_wstrb;
  logic         dresp_valid;
  logic [63:0]  dresp_rdata;

  logic         mem_to_wb_valid;
  logic         wb_allowin;
  logic [230:0] mem_to_wb_bus;

  modport master (
    input  ex_to_mem_valid, ex_to_mem_bus, mem_flush,
           dreq_ready, dresp_valid, dresp_rdata, wb_allowin,
    output mem_allowin, dreq_valid, dreq_addr, dreq_wen, dreq_wdata, dreq_wstrb,
           mem_to_wb_valid, mem_to_wb_bus
  );

  modport slave (
    output ex_to_mem_valid, ex_to_mem_bus, mem_flush,
           dreq_ready, dresp_valid, dresp_rdata, wb_allowin,
    input  mem_allowin, dreq_valid, dreq_addr, dreq_wen, dreq_wdata, dreq_wstrb,
           mem_to_wb_valid, mem_to_wb_bus
  );
endinterface

// File: rtl/ysyx_22040127_mem_stage.sv
// MEM pipeline stage: holds one EX instruction, performs its load/store on the
// data-memory port, aligns/extends load data and hands the result to WB.
module ysyx_22040127_mem_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = 32
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22040127_mem_stage_if.master io
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t            state;
  logic              mem_valid;
  logic [PC_W-1:0]   pc_q;
  logic [4:0]        rd_q;
  logic              reg_wen_q, mem_read_q, mem_write_q, uns_q;
  logic [1:0]        size_q;
  logic [XLEN-1:0]   store_data_q, alu_q, load_q;

  logic              dreq_valid_q, dreq_wen_q;
  logic [31:0]       dreq_addr_q;
  logic [XLEN-1:0]   dreq_wdata_q;
  logic [7:0]        dreq_wstrb_q;

  logic [XLEN-1:0]   in_alu, in_sd;
  logic [1:0]        in_size;
  logic [2:0]        in_sh;
  logic              in_mem_op;
  logic [7:0]        strb_base, in_strb;

  logic              ready_go, mem_allowin, accept, start_req;
  logic [XLEN-1:0]   rshift, load_ext, diff_data, reg_wdata;

  assign in_alu    = io.ex_to_mem_bus[63:0];
  assign in_sd     = io.ex_to_mem_bus[127:64];
  assign in_size   = io.ex_to_mem_bus[130:129];
  assign in_mem_op = io.ex_to_mem_bus[132] | io.ex_to_mem_bus[131];
  assign in_sh     = in_alu[2:0];

  // DRAIN keeps the stage closed even though mem_valid is already cleared.
  assign ready_go    = mem_valid & (~(mem_read_q | mem_write_q) | (state == DONE));
  assign mem_allowin = (state != DRAIN) & (~mem_valid | (ready_go & io.wb_allowin));
  assign accept      = mem_allowin & io.ex_to_mem_valid & ~io.mem_flush;
  assign start_req   = accept & in_mem_op;

  always_comb begin
    strb_base = 8'h01;
    case (in_size)
      2'd0: strb_base = 8'h01;
      2'd1: strb_base = 8'h03;
      2'd2: strb_base = 8'h0F;
      2'd3: strb_base = 8'hFF;
      default: strb_base = 8'h01;
    endcase
  end
  assign in_strb = strb_base << in_sh;

  assign rshift = io.dresp_rdata >> {alu_q[2:0], 3'b000};

  always_comb begin
    load_ext  = rshift;
    diff_data = store_data_q;
    case (size_q)
      2'd0: begin
        load_ext  = uns_q ? {{(XLEN-8){1'b0}}, rshift[7:0]} : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
        diff_data = {{(XLEN-8){1'b0}}, store_data_q[7:0]};
      end
      2'd1: begin
        load_ext  = uns_q ? {{(XLEN-16){1'b0}}, rshift[15:0]} : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
        diff_data = {{(XLEN-16){1'b0}}, store_data_q[15:0]};
      end
      2'd2: begin
        load_ext  = uns_q ? {{(XLEN-32){1'b0}}, rshift[31:0]} : {{(XLEN-32){rshift[31]}}, rshift[31:0]};
        diff_data = {{(XLEN-32){1'b0}}, store_data_q[31:0]};
      end
      default: begin
        load_ext  = rshift;
        diff_data = store_data_q;
      end
    endcase
  end

  assign reg_wdata = mem_read_q ? load_q : alu_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_valid    <= 1'b0;
      pc_q         <= '0;
      rd_q         <= '0;
      reg_wen_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      store_data_q <= '0;
      alu_q        <= '0;
      load_q       <= '0;
      dreq_valid_q <= 1'b0;
      dreq_wen_q   <= 1'b0;
      dreq_addr_q  <= '0;
      dreq_wdata_q <= '0;
      dreq_wstrb_q <= '0;
    end else begin
      if (mem_allowin) begin
        mem_valid <= io.ex_to_mem_valid & ~io.mem_flush;
        if (io.ex_to_mem_valid) begin
          pc_q         <= io.ex_to_mem_bus[170:139];
          rd_q         <= io.ex_to_mem_bus[138:134];
          reg_wen_q    <= io.ex_to_mem_bus[133];
          mem_read_q   <= io.ex_to_mem_bus[132];
          mem_write_q  <= io.ex_to_mem_bus[131];
          size_q       <= in_size;
          uns_q        <= io.ex_to_mem_bus[128];
          store_data_q <= in_sd;
          alu_q        <= in_alu;
        end
      end else if (io.mem_flush) begin
        mem_valid <= 1'b0;
      end

      if (start_req) begin
        dreq_addr_q  <= {in_alu[31:3], 3'b000};
        dreq_wen_q   <= io.ex_to_mem_bus[131];
        dreq_wdata_q <= in_sd << {in_sh, 3'b000};
        dreq_wstrb_q <= in_strb;
      end

      case (state)
        IDLE: begin
          if (start_req) begin
            state        <= REQ;
            dreq_valid_q <= 1'b1;
          end
        end
        REQ: begin
          // A request accepted in the flush cycle still owes a response.
          if (io.mem_flush) begin
            dreq_valid_q <= 1'b0;
            state        <= io.dreq_ready ? DRAIN : IDLE;
          end else if (io.dreq_ready) begin
            dreq_valid_q <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (io.dresp_valid) begin
            if (io.mem_flush) begin
              state <= IDLE;
            end else begin
              load_q <= load_ext;
              state  <= DONE;
            end
          end else if (io.mem_flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          if (io.mem_flush) begin
            state <= IDLE;
          end else if (io.wb_allowin) begin
            if (start_req) begin
              state        <= REQ;
              dreq_valid_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (io.dresp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.mem_allowin     = mem_allowin;
  assign io.dreq_valid      = dreq_valid_q;
  assign io.dreq_addr       = dreq_addr_q;
  assign io.dreq_wen        = dreq_wen_q;
  assign io.dreq_wdata      = dreq_wdata_q;
  assign io.dreq_wstrb      = dreq_wstrb_q;
  assign io.mem_to_wb_valid = ready_go & ~io.mem_flush;
  assign io.mem_to_wb_bus   = {mem_write_q, diff_data, alu_q, pc_q, reg_wen_q, rd_q, reg_wdata};
endmodule

// File: tb/tb_ysyx_22040127_mem_stage.sv
// Scoreboard bench for the MEM stage: directed vectors, a simple memory responder,
// and monitors that pop expected requests / WB transfers as the DUT presents them.
module tb_ysyx_22040127_mem_stage;
  logic clk;
  logic rst;

  ysyx_22040127_mem_stage_if io ();

  ysyx_22040127_mem_stage #(.XLEN(64), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned  n_pass;
  int unsigned  n_total;
  logic [230:0] wbq[$];
  logic [104:0] rq[$];
  int unsigned  rdy_delay;
  int unsigned  resp_delay;
  logic [63:0]  mem_rdata;

  function automatic void chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endfunction

  function automatic logic [170:0] mk_ex(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                                         input logic mr, input logic mw, input logic [1:0] sz,
                                         input logic u, input logic [63:0] sd, input logic [63:0] alu);
    return {pc, rd, wen, mr, mw, sz, u, sd, alu};
  endfunction

  function automatic logic [230:0] mk_wb(input logic mw, input logic [63:0] dd, input logic [63:0] da,
                                         input logic [31:0] pc, input logic wen, input logic [4:0] rd,
                                         input logic [63:0] wd);
    return {mw, dd, da, pc, wen, rd, wd};
  endfunction

  function automatic logic [104:0] mk_req(input logic [31:0] a, input logic w, input logic [63:0] d,
                                          input logic [7:0] s);
    return {a, w, d, s};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the latching edge.
  task automatic send(input logic [170:0] b);
    bit ok;
    ok = 1'b0;
    io.ex_to_mem_valid = 1'b1;
    io.ex_to_mem_bus   = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = io.mem_allowin;
      @(posedge clk); #1;
    end
    io.ex_to_mem_valid = 1'b0;
    if (!ok) chk1("send_timeout", ok, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (wbq.size() != 0 || rq.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    if (wbq.size() != 0) chkw("drain_wb_timeout", 256'(wbq.size()), 256'(0));
    if (rq.size() != 0)  chkw("drain_req_timeout", 256'(rq.size()), 256'(0));
  endtask

  // Memory model: ready after rdy_delay cycles of dreq_valid, one response pulse
  // resp_delay cycles after the accepting edge.
  initial begin : responder
    bit          hs;
    bit          pending;
    int unsigned wait_cnt;
    int unsigned resp_cnt;
    pending  = 1'b0;
    wait_cnt = 0;
    resp_cnt = 0;
    io.dreq_ready  = 1'b0;
    io.dresp_valid = 1'b0;
    io.dresp_rdata = '0;
    forever begin
      @(negedge clk);
      hs = io.dreq_valid && io.dreq_ready;
      @(posedge clk); #1;
      io.dresp_valid = 1'b0;
      if (rst) begin
        pending       = 1'b0;
        wait_cnt      = 0;
        io.dreq_ready = 1'b0;
      end else begin
        if (hs) begin
          pending  = 1'b1;
          resp_cnt = resp_delay;
        end
        if (pending) begin
          if (resp_cnt == 0) begin
            io.dresp_valid = 1'b1;
            io.dresp_rdata = mem_rdata;
            pending        = 1'b0;
          end else begin
            resp_cnt--;
          end
        end
        if (io.dreq_valid) begin
          if (wait_cnt >= rdy_delay) io.dreq_ready = 1'b1;
          else begin
            io.dreq_ready = 1'b0;
            wait_cnt++;
          end
        end else begin
          io.dreq_ready = 1'b0;
          wait_cnt      = 0;
        end
      end
    end
  end

  initial begin : wb_mon
    logic [230:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && io.mem_to_wb_valid && io.wb_allowin) begin
        if (wbq.size() == 0) chk1("wb_unexpected", io.mem_to_wb_valid, 1'b0);
        else begin
          exp = wbq.pop_front();
          chkw("wb_bus", 256'(io.mem_to_wb_bus), 256'(exp));
        end
      end
    end
  end

  initial begin : req_mon
    logic [104:0] cur, prev, exp;
    bit           prev_live;
    prev_live = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      cur = {io.dreq_addr, io.dreq_wen, io.dreq_wdata, io.dreq_wstrb};
      if (!rst && io.dreq_valid) begin
        if (prev_live) chkw("dreq_stable", 256'(cur), 256'(prev));
        if (io.dreq_ready) begin
          if (rq.size() == 0) chk1("dreq_unexpected", io.dreq_ready, 1'b0);
          else begin
            exp = rq.pop_front();
            chkw("dreq_fields", 256'(cur), 256'(exp));
          end
        end
      end
      prev_live = !rst && io.dreq_valid && !io.dreq_ready;
      prev      = cur;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [230:0] bp_exp;
    int unsigned  lat;
    bit           seen;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    io.ex_to_mem_valid = 1'b0;
    io.ex_to_mem_bus   = '0;
    io.mem_flush       = 1'b0;
    io.wb_allowin      = 1'b1;
    rdy_delay  = 0;
    resp_delay = 0;
    mem_rdata  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_allowin", io.mem_allowin, 1'b1);
    chk1("rst_wb_valid", io.mem_to_wb_valid, 1'b0);
    chk1("rst_dreq_valid", io.dreq_valid, 1'b0);
    chkw("rst_wb_bus", 256'(io.mem_to_wb_bus), 256'(0));
    chkw("rst_dreq_wstrb", 256'(io.dreq_wstrb), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU pass-through
    wbq.push_back(mk_wb(1'b0, 64'h0, 64'h1234, 32'h8000_0000, 1'b1, 5'd5, 64'h1234));
    send(mk_ex(32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h1234));
    @(negedge clk);
    chk1("alu_valid_next", io.mem_to_wb_valid, 1'b1);
    chk1("alu_no_dreq", io.dreq_valid, 1'b0);
    @(posedge clk); #1;
    drain();

    // lb / lbu at byte 3
    mem_rdata = 64'h0000_0000_8000_0000;
    rq.push_back(mk_req(32'h8000_0000, 1'b0, 64'h0, 8'h08));
    wbq.push_back(mk_wb(1'b0, 64'h0, 64'h8000_0003, 32'h8000_0004, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FF80));
    send(mk_ex(32'h8000_0004, 5'd6, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h0, 64'h8000_0003));
    drain();
    rq.push_back(mk_req(32'h8000_0000, 1'b0, 64'h0, 8'h08));
    wbq.push_back(mk_wb(1'b0, 64'h0, 64'h8000_0003, 32'h8000_0008, 1'b1, 5'd7, 64'h80));
    send(mk_ex(32'h8000_0008, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 64'h0, 64'h8000_0003));
    drain();

    // sh at offset 6, then misaligned sw at offset 6 (strobes truncated)
    rq.push_back(mk_req(32'h8000_0000, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0));
    wbq.push_back(mk_wb(1'b1, 64'hABCD, 64'h8000_0006, 32'h8000_000C, 1'b0, 5'd0, 64'h8000_0006));
    send(mk_ex(32'h8000_000C, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 64'h1111_2222_3333_ABCD, 64'h8000_0006));
    drain();
    rq.push_back(mk_req(32'h8000_0000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0));
    wbq.push_back(mk_wb(1'b1, 64'hDEAD_BEEF, 64'h8000_0006, 32'h8000_0010, 1'b0, 5'd0, 64'h8000_0006));
    send(mk_ex(32'h8000_0010, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 64'hDEAD_BEEF, 64'h8000_0006));
    drain();

    // lw signed at offset 4, lh signed at offset 2
    mem_rdata = 64'h8765_4321_0000_0000;
    rq.push_back(mk_req(32'h8000_0010, 1'b0, 64'h0, 8'hF0));
    wbq.push_back(mk_wb(1'b0, 64'h0, 64'h8000_0014, 32'h8000_0014, 1'b1, 5'd8, 64'hFFFF_FFFF_8765_4321));
    send(mk_ex(32'h8000_0014, 5'd8, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h0, 64'h8000_0014));
    drain();
    mem_rdata = 64'h0000_0000_F00D_0000;
    rq.push_back(mk_req(32'h8000_0018, 1'b0, 64'h0, 8'h0C));
    wbq.push_back(mk_wb(1'b0, 64'h0, 64'h8000_001A, 32'h8000_0018, 1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_F00D));
    send(mk_ex(32'h8000_0018, 5'd10, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 64'h0, 64'h8000_001A));
    drain();

    // ld with ready held low 3 cycles and response 2 cycles after acceptance
    rdy_delay  = 3;
    resp_delay = 2;
    mem_rdata  = 64'h0123_4567_89AB_CDEF;
    rq.push_back(mk_req(32'h8000_0020, 1'b0, 64'h0, 8'hFF));
    wbq.push_back(mk_wb(1'b0, 64'h0, 64'h8000_0020, 32'h8000_0020, 1'b1, 5'd11, 64'h0123_4567_89AB_CDEF));
    send(mk_ex(32'h8000_0020, 5'd11, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'h8000_0020));
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (io.mem_to_wb_valid) begin
        seen = 1'b1;
        lat  = i;
        chk1("slow_allowin_done", io.mem_allowin, 1'b1);
      end else begin
        chk1("slow_allowin_busy", io.mem_allowin, 1'b0);
      end
      @(posedge clk); #1;
    end
    chkw("slow_latency", 256'(lat), 256'(8));
    drain();

    // flush while the request is still unaccepted
    rdy_delay  = 10;
    resp_delay = 0;
    send(mk_ex(32'h8000_0028, 5'd12, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h0, 64'h8000_0028));
    @(negedge clk);
    chk1("req_flush_pre_dreq", io.dreq_valid, 1'b1);
    @(posedge clk); #1;
    io.mem_flush = 1'b1;
    @(negedge clk);
    chk1("req_flush_wb_valid", io.mem_to_wb_valid, 1'b0);
    @(posedge clk); #1;
    io.mem_flush = 1'b0;
    @(negedge clk);
    chk1("req_flush_dreq_drop", io.dreq_valid, 1'b0);
    chk1("req_flush_allowin", io.mem_allowin, 1'b1);
    @(posedge clk); #1;

    // flush in WAIT: response is drained and dropped
    rdy_delay  = 0;
    resp_delay = 3;
    rq.push_back(mk_req(32'h8000_0030, 1'b0, 64'h0, 8'hFF));
    send(mk_ex(32'h8000_0030, 5'd12, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'h8000_0030));
    @(posedge clk); #1;
    io.mem_flush = 1'b1;
    @(negedge clk);
    chk1("wait_flush_wb_valid", io.mem_to_wb_valid, 1'b0);
    @(posedge clk); #1;
    io.mem_flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      chk1("drain_wb_valid", io.mem_to_wb_valid, 1'b0);
      chk1("drain_allowin", io.mem_allowin, 1'b0);
      seen = io.dresp_valid;
      @(posedge clk); #1;
    end
    chk1("drain_resp_seen", seen, 1'b1);
    @(negedge clk);
    chk1("drain_release_allowin", io.mem_allowin, 1'b1);
    chk1("drain_release_wb_valid", io.mem_to_wb_valid, 1'b0);
    @(posedge clk); #1;

    // WB backpressure in DONE for 4 cycles, then exactly one transfer
    resp_delay    = 0;
    mem_rdata     = 64'hFEDC_BA98_7654_3210;
    io.wb_allowin = 1'b0;
    bp_exp = mk_wb(1'b0, 64'h0, 64'h8000_0038, 32'h8000_0038, 1'b1, 5'd12, 64'hFEDC_BA98_7654_3210);
    rq.push_back(mk_req(32'h8000_0038, 1'b0, 64'h0, 8'hFF));
    wbq.push_back(bp_exp);
    send(mk_ex(32'h8000_0038, 5'd12, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'h8000_0038));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = io.mem_to_wb_valid;
      if (!seen) begin
        @(posedge clk); #1;
      end
    end
    chk1("bp_reached_done", seen, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("bp_valid_held", io.mem_to_wb_valid, 1'b1);
      chkw("bp_bus_held", 256'(io.mem_to_wb_bus), 256'(bp_exp));
      chk1("bp_allowin", io.mem_allowin, 1'b0);
      chk1("bp_no_dreq", io.dreq_valid, 1'b0);
      @(posedge clk); #1;
      if (i == 3) io.wb_allowin = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk1("bp_single_transfer", io.mem_to_wb_valid, 1'b0);
    @(posedge clk); #1;

    // reset asserted mid-WAIT clears outputs immediately
    resp_delay = 3;
    rq.push_back(mk_req(32'h8000_0040, 1'b0, 64'h0, 8'hFF));
    send(mk_ex(32'h8000_0040, 5'd13, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'h8000_0040));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk1("midrst_allowin", io.mem_allowin, 1'b1);
    chk1("midrst_wb_valid", io.mem_to_wb_valid, 1'b0);
    chk1("midrst_dreq_valid", io.dreq_valid, 1'b0);
    chkw("midrst_wb_bus", 256'(io.mem_to_wb_bus), 256'(0));
    chkw("midrst_dreq_addr", 256'(io.dreq_addr), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    resp_delay = 0;
    wbq.push_back(mk_wb(1'b0, 64'h0, 64'h55, 32'h8000_0044, 1'b1, 5'd13, 64'h55));
    send(mk_ex(32'h8000_0044, 5'd13, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h55));
    drain();

    repeat (3) @(posedge clk);
    chkw("wb_queue_empty", 256'(wbq.size()), 256'(0));
    chkw("req_queue_empty", 256'(rq.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
